// File: rtl/sprite_compositor.sv
// N-slot sprite compositor: two-band background with a black horizon row, overlaid
// with RGB565 sprites read from external sync ROMs, through a 3-stage pixel pipeline.
module sprite_compositor #(
  parameter int          NSPR     = 8,
  parameter int          SPR_W    = 32,
  parameter int          SPR_H    = 32,
  parameter int          ANIM_DIV = 6,
  parameter logic [15:0] KEY      = 16'hF81F,
  parameter int          AW       = $clog2(SPR_W*SPR_H)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               chipselect,
  input  logic               write,
  input  logic [8:0]         address,
  input  logic [31:0]        writedata,
  input  logic [10:0]        hcount,
  input  logic [9:0]         vcount,
  input  logic               blank_n,
  input  logic               frame_start,
  output logic [NSPR*AW-1:0] spr_addr,
  output logic [NSPR-1:0]    spr_phase,
  input  logic [NSPR*16-1:0] spr_data,
  output logic [23:0]        rgb,
  output logic               blank_n_out
);

  localparam int XW = $clog2(SPR_W);
  localparam int YW = AW - XW;
  localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  localparam logic [23:0] SKY_RST     = 24'h87CEEB;
  localparam logic [23:0] GROUND_RST  = 24'h8B4513;
  localparam logic [9:0]  HORIZON_RST = 10'd200;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       anim_en;
    logic       hflip;
    logic       enable;
  } slot_t;

  slot_t         shadow_q [NSPR];
  slot_t         shadow_d [NSPR];
  slot_t         active_q [NSPR];
  slot_t         active_d [NSPR];
  logic [23:0]   sky_sh_q, sky_sh_d, sky_q, sky_d;
  logic [23:0]   gnd_sh_q, gnd_sh_d, gnd_q, gnd_d;
  logic [9:0]    hor_sh_q, hor_sh_d, hor_q, hor_d;
  logic [CW-1:0] anim_cnt_q, anim_cnt_d;
  logic          phase_q, phase_d;

  logic [10:0]      px, vy;
  logic [NSPR-1:0]  hit1_q, hit1_d, hit2_q, hit2_d;
  logic [AW-1:0]    addr_q [NSPR];
  logic [AW-1:0]    addr_d [NSPR];
  logic [XW-1:0]    dx [NSPR];
  logic [XW-1:0]    col [NSPR];
  logic [YW-1:0]    dy [NSPR];
  logic [23:0]      bg1_q, bg1_d, bg2_q, bg2_d;
  logic             blank1_q, blank1_d, blank2_q, blank2_d;
  logic [23:0]      rgb_q, rgb_d;
  logic             blank_out_q, blank_out_d;
  logic             found;

  logic             wr_en;
  logic [4:0]       wr_slot;
  logic             unused_ok;

  assign wr_en     = chipselect & write;
  assign wr_slot   = address[6:2];
  assign unused_ok = ^{writedata[31:24], hcount[0]};

  function automatic logic visible(input logic [15:0] p);
    return (p != KEY) && !((p[15:11] > 5'd28) && (p[10:5] > 6'd60) && (p[4:0] > 5'd28));
  endfunction

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] p);
    return {p[15:11], 3'b000, p[10:5], 2'b00, p[4:0], 3'b000};
  endfunction

  always_comb begin : reg_write
    shadow_d = shadow_q;
    sky_sh_d = sky_sh_q;
    gnd_sh_d = gnd_sh_q;
    hor_sh_d = hor_sh_q;
    if (wr_en && !address[8] && !address[7]) begin
      // Slot numbers at or above NSPR match no loop index and are dropped.
      for (int i = 0; i < NSPR; i++) begin
        if (wr_slot == 5'(i)) begin
          case (address[1:0])
            2'd0:    shadow_d[i].x = writedata[9:0];
            2'd1:    shadow_d[i].y = writedata[9:0];
            2'd2:    {shadow_d[i].anim_en, shadow_d[i].hflip, shadow_d[i].enable} = writedata[2:0];
            default: ;
          endcase
        end
      end
    end else if (wr_en && address[8]) begin
      case (address[7:0])
        8'd0:    sky_sh_d = writedata[23:0];
        8'd1:    gnd_sh_d = writedata[23:0];
        8'd2:    hor_sh_d = writedata[9:0];
        default: ;
      endcase
    end
  end

  // Commit reads the pre-write shadow, so a write coinciding with frame_start waits a frame.
  always_comb begin : commit
    active_d = active_q;
    sky_d    = sky_q;
    gnd_d    = gnd_q;
    hor_d    = hor_q;
    if (frame_start) begin
      active_d = shadow_q;
      sky_d    = sky_sh_q;
      gnd_d    = gnd_sh_q;
      hor_d    = hor_sh_q;
    end
  end

  always_comb begin : anim_next
    anim_cnt_d = anim_cnt_q;
    phase_d    = phase_q;
    if (frame_start) begin
      if (anim_cnt_q == CW'(ANIM_DIV - 1)) begin
        anim_cnt_d = '0;
        phase_d    = ~phase_q;
      end else begin
        anim_cnt_d = anim_cnt_q + 1'b1;
      end
    end
  end

  assign px = {1'b0, hcount[10:1]};
  assign vy = {1'b0, vcount};

  // Stage 1: hit test and ROM address. 11-bit bounds never wrap, so sprites clip at edges.
  always_comb begin : s1_hit
    for (int i = 0; i < NSPR; i++) begin
      hit1_d[i] = active_q[i].enable
                  && (px >= {1'b0, active_q[i].x}) && (px < {1'b0, active_q[i].x} + 11'(SPR_W))
                  && (vy >= {1'b0, active_q[i].y}) && (vy < {1'b0, active_q[i].y} + 11'(SPR_H));
      dx[i]     = XW'(px - {1'b0, active_q[i].x});
      dy[i]     = YW'(vy - {1'b0, active_q[i].y});
      col[i]    = active_q[i].hflip ? XW'(SPR_W - 1) - dx[i] : dx[i];
      addr_d[i] = hit1_d[i] ? {dy[i], col[i]} : addr_q[i];
    end
    if (vcount == hor_q)     bg1_d = '0;
    else if (vcount < hor_q) bg1_d = sky_q;
    else                     bg1_d = gnd_q;
    blank1_d = blank_n;
  end

  // Stage 2: ROM data is in flight; delay the side-band to meet it.
  always_comb begin : s2_align
    hit2_d   = hit1_q;
    bg2_d    = bg1_q;
    blank2_d = blank1_q;
  end

  // Stage 3: lowest-index visible hit wins, else background; blanking forces black.
  always_comb begin : s3_select
    // NOTE: every variable written here gets a default first, so no path can leave
    // it unassigned and infer a latch.
    rgb_d = bg2_q;
    found = 1'b0;
    for (int i = 0; i < NSPR; i++) begin
      if (!found && hit2_q[i] && visible(spr_data[i*16 +: 16])) begin
        rgb_d = rgb565_to_888(spr_data[i*16 +: 16]);
        found = 1'b1;
      end
    end
    if (!blank2_q) rgb_d = '0;
    blank_out_d = blank2_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: slot registers are plain flops rather than a RAM, so they are reset too;
      // that keeps every sprite disabled until software writes and commits it.
      for (int i = 0; i < NSPR; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
        addr_q[i]   <= '0;
      end
      sky_sh_q    <= SKY_RST;
      gnd_sh_q    <= GROUND_RST;
      hor_sh_q    <= HORIZON_RST;
      sky_q       <= SKY_RST;
      gnd_q       <= GROUND_RST;
      hor_q       <= HORIZON_RST;
      anim_cnt_q  <= '0;
      phase_q     <= 1'b0;
      hit1_q      <= '0;
      hit2_q      <= '0;
      bg1_q       <= '0;
      bg2_q       <= '0;
      blank1_q    <= 1'b0;
      blank2_q    <= 1'b0;
      rgb_q       <= '0;
      blank_out_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // independent of statement order.
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      addr_q      <= addr_d;
      sky_sh_q    <= sky_sh_d;
      gnd_sh_q    <= gnd_sh_d;
      hor_sh_q    <= hor_sh_d;
      sky_q       <= sky_d;
      gnd_q       <= gnd_d;
      hor_q       <= hor_d;
      anim_cnt_q  <= anim_cnt_d;
      phase_q     <= phase_d;
      hit1_q      <= hit1_d;
      hit2_q      <= hit2_d;
      bg1_q       <= bg1_d;
      bg2_q       <= bg2_d;
      blank1_q    <= blank1_d;
      blank2_q    <= blank2_d;
      rgb_q       <= rgb_d;
      blank_out_q <= blank_out_d;
    end
  end

  for (genvar g = 0; g < NSPR; g++) begin : g_out
    assign spr_addr[g*AW +: AW] = addr_q[g];
    assign spr_phase[g]         = active_q[g].anim_en & phase_q;
  end

  assign rgb         = rgb_q;
  assign blank_n_out = blank_out_q;

endmodule
